// File: rtl/aes_block_loader.sv
// aes_block_loader: packs an 8-bit message stream into 128-bit AES state
// blocks and hands each block to the AES control stage over valid/ready.
// The final block of a message is flagged with blk_last.
//
// Build option: define AES_LOADER_PAD_EN to enable PKCS#7 padding (PAD state
// and pending-pad flag). Without it, a short final block is zero-filled.
//
// Byte placement is set by MSB_FIRST: 1 puts the first byte in
// blk_out[127:120], 0 puts it in blk_out[7:0].

module aes_block_loader #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] blk_out,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_last
);

  // State encodings are fixed so both builds decode HOLD the same way.
`ifdef AES_LOADER_PAD_EN
  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    HOLD = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd2
  } state_t;
`endif

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   blk_q, blk_d;
  logic           last_q, last_d;
  // Low through reset and for the first edge after it, so in_ready stays
  // low while rst is high even though the state already reads FILL.
  logic           run_q;
`ifdef AES_LOADER_PAD_EN
  logic [4:0]     pad_q, pad_d;
  logic           pend_q, pend_d;
`endif

  logic byte_acc;
  logic blk_acc;

  // Writes one byte into the block at byte index idx, honouring MSB_FIRST.
  function automatic logic [127:0] put_byte(input logic [127:0] b,
                                            input logic [3:0]   idx,
                                            input logic [7:0]   d);
    logic [127:0] r;
    logic [3:0]   lane;
    r    = b;
    lane = MSB_FIRST ? ~idx : idx;
    r[{lane, 3'b000} +: 8] = d;
    return r;
  endfunction

  // Outputs decode registered state only; no path from in_valid/blk_ready.
  assign in_ready  = run_q && (state_q == FILL);
  assign blk_valid = (state_q == HOLD);
  assign blk_out   = blk_q;
  assign blk_last  = last_q;

  assign byte_acc = in_valid && in_ready;
  assign blk_acc  = blk_valid && blk_ready;

  // Next-state logic: byte packing, padding and block handoff.
  always_comb begin
    // NOTE: every variable gets a default here first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    last_d  = last_q;
`ifdef AES_LOADER_PAD_EN
    pad_d   = pad_q;
    pend_d  = pend_q;
`endif

    case (state_q)
      FILL: begin
        if (byte_acc) begin
          blk_d = put_byte(blk_q, cnt_q, in_data);
          if (cnt_q == 4'd15) begin
            // Block full; cnt stays at 15 until the handoff clears it.
            state_d = HOLD;
            last_d  = in_last;
`ifdef AES_LOADER_PAD_EN
            // Exact multiple of 16: the last marker moves to an extra
            // all-0x10 block sent after this one.
            if (in_last) begin
              pend_d = 1'b1;
              last_d = 1'b0;
            end
`endif
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (in_last) begin
`ifdef AES_LOADER_PAD_EN
              state_d = PAD;
              pad_d   = 5'd15 - {1'b0, cnt_q};
`else
              // Remaining bytes are already zero from the last handoff.
              state_d = HOLD;
              last_d  = 1'b1;
`endif
            end
          end
        end
      end

`ifdef AES_LOADER_PAD_EN
      PAD: begin
        blk_d = put_byte(blk_q, cnt_q, {3'b000, pad_q});
        if (cnt_q == 4'd15) begin
          state_d = HOLD;
          last_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`endif

      HOLD: begin
        if (blk_acc) begin
          blk_d  = '0;
          cnt_d  = 4'd0;
          last_d = 1'b0;
`ifdef AES_LOADER_PAD_EN
          if (pend_q) begin
            pend_d  = 1'b0;
            pad_d   = 5'd16;
            state_d = PAD;
          end else begin
            state_d = FILL;
          end
`else
          state_d = FILL;
`endif
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= 4'd0;
      // NOTE: the block buffer is a plain register, not a memory array, so
      // it is reset with everything else; blk_out must read 0 in reset.
      blk_q   <= '0;
      last_q  <= 1'b0;
      run_q   <= 1'b0;
`ifdef AES_LOADER_PAD_EN
      pad_q   <= 5'd0;
      pend_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before this edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      last_q  <= last_d;
      run_q   <= 1'b1;
`ifdef AES_LOADER_PAD_EN
      pad_q   <= pad_d;
      pend_q  <= pend_d;
`endif
    end
  end

`ifndef SYNTHESIS
  // A stalled block must not change under the consumer.
  property p_hold_stable;
    @(posedge clk) disable iff (rst)
      (blk_valid && !blk_ready) |=>
        (blk_valid && $stable(blk_out) && $stable(blk_last));
  endproperty
  a_hold_stable: assert property (p_hold_stable);

`ifdef AES_LOADER_PAD_EN
  // PKCS#7 pad byte is always 1..16.
  property p_pad_range;
    @(posedge clk) disable iff (rst)
      (state_q == PAD) |-> (pad_q >= 5'd1 && pad_q <= 5'd16);
  endproperty
  a_pad_range: assert property (p_pad_range);
`endif
`endif

endmodule
